mem_arbiter_6502: RTL and testbench

Two-master arbiter that shares the SoC's single-port synchronous RAM between the 6502 CPU and a DMA requester (loader or peripheral engine). The CPU owns the RAM by default and is stalled through its RDY input while DMA holds the bus. A burst limit guarantees the CPU one access slot after every `DMA_MAX_BURST` consecutive DMA cycles. The block sits between the CPU core, the DMA port and the RAM inside `soc_6502`.

---
 rtl/mem_arbiter_6502.sv | 135 +++++++++++++
 tb/tb_mem_arbiter_6502.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_6502.sv
// -----------------------------------------------------------------------------
// mem_arbiter_6502
// Shares one single-port synchronous RAM between the 6502 CPU and a DMA
// requester. The CPU owns the RAM by default. DMA takes the bus whenever it
// requests, but after DMA_MAX_BURST back-to-back DMA cycles the CPU is given
// one access slot. The CPU is stalled through cpu_rdy while DMA owns the RAM.
//
// Ports:
//   clk, reset        : system clock, asynchronous active-low reset
//   cpu_addr/dout/we  : CPU access request; cpu_din/cpu_rdy back to the core
//   dma_req/addr/wdata/we : DMA access request (one access per cycle)
//   dma_gnt           : DMA owns the RAM this cycle (combinational)
//   dma_ack/dma_rdata : previous-cycle DMA access completed / its read data
//   mem_addr/wdata/we : RAM port, mem_rdata returns one cycle later
// -----------------------------------------------------------------------------
module mem_arbiter_6502 #(
    parameter int AW            = 16,
    parameter int DW            = 8,
    parameter int DMA_MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_dout,
    input  logic          cpu_we,
    output logic [DW-1:0] cpu_din,
    output logic          cpu_rdy,
    input  logic          dma_req,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    input  logic          dma_we,
    output logic          dma_gnt,
    output logic          dma_ack,
    output logic [DW-1:0] dma_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [7:0] BURST_LIMIT = 8'(DMA_MAX_BURST);

    logic [7:0]    burst_cnt_r;
    logic          owner_q_r;
    logic          dma_ack_r;
    logic [DW-1:0] dma_rdata_r;
    logic [DW-1:0] cpu_hold_r;
    logic          dma_gnt_s;

    // Grant decision; reset low forces the CPU onto the bus at once.
    always_comb begin
        dma_gnt_s = 1'b0;
        if (!reset) begin
            dma_gnt_s = 1'b0;
        end else if (dma_req && (burst_cnt_r < BURST_LIMIT)) begin
            dma_gnt_s = 1'b1;
        end else begin
            dma_gnt_s = 1'b0;
        end
    end

    // RAM port mux; only the granted master's write enable reaches the RAM.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_dout;
        mem_we    = 1'b0;
        if (dma_gnt_s) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_we    = dma_we;
        end else if (reset) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_dout;
            mem_we    = cpu_we;
        end else begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_dout;
            mem_we    = 1'b0;
        end
    end

    // Read-data steering: the RAM answers for last cycle's owner, the other
    // master sees its holding register so its data does not move.
    always_comb begin
        cpu_din   = mem_rdata;
        dma_rdata = dma_rdata_r;
        if (owner_q_r) begin
            cpu_din   = cpu_hold_r;
            dma_rdata = mem_rdata;
        end else begin
            cpu_din   = mem_rdata;
            dma_rdata = dma_rdata_r;
        end
    end

    assign dma_gnt = dma_gnt_s;
    assign cpu_rdy = ~dma_gnt_s;
    assign dma_ack = dma_ack_r;

    // Burst counter: counts consecutive grants; any non-DMA cycle restarts it.
    // The grant stops at BURST_LIMIT, so the count never passes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            burst_cnt_r <= 8'd0;
        end else if (dma_gnt_s) begin
            burst_cnt_r <= burst_cnt_r + 8'd1;
        end else begin
            burst_cnt_r <= 8'd0;
        end
    end

    // Ownership of the in-flight RAM read and the DMA completion strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q_r <= 1'b0;
            dma_ack_r <= 1'b0;
        end else begin
            owner_q_r <= dma_gnt_s;
            dma_ack_r <= dma_gnt_s;
        end
    end

    // Holding registers: each captures RAM data while its master owns the read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dma_rdata_r <= '0;
            cpu_hold_r  <= '0;
        end else if (owner_q_r) begin
            dma_rdata_r <= mem_rdata;
        end else begin
            cpu_hold_r  <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter_6502.sv
module tb_mem_arbiter_6502;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_we;
    logic [7:0]  cpu_din;
    logic        cpu_rdy;
    logic        dma_req;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_we;
    logic        dma_gnt;
    logic        dma_ack;
    logic [7:0]  dma_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;

    // backdoor preload port of the RAM model
    logic        bd_we;
    logic [9:0]  bd_addr;
    logic [7:0]  bd_data;
    logic [7:0]  ram [0:1023];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic req;
        logic exp_gnt;
        logic exp_ack;
    } vec_t;
    vec_t vecs [22];

    always #5 clk = ~clk;

    mem_arbiter_6502 #(.AW(16), .DW(8), .DMA_MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we),
        .cpu_din(cpu_din), .cpu_rdy(cpu_rdy),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_we(dma_we), .dma_gnt(dma_gnt), .dma_ack(dma_ack),
        .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    // Synchronous RAM model, one-cycle read latency, read returns old data.
    always @(posedge clk) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        else if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[9:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [9:0] a, input logic [7:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        next_cycle();
        bd_we = 1'b0;
    endtask

    initial begin
        logic [21:0] req_pat;
        logic [21:0] gnt_pat;
        logic [21:0] ack_pat;
        logic        g;

        // cycle-ordered patterns, leftmost character is vector 0
        req_pat = 22'b1111111111110110111110;
        gnt_pat = 22'b1111011110110110111100;
        ack_pat = 22'b0111101111011011011110;
        for (int i = 0; i < 22; i++) begin
            vecs[i].req     = req_pat[21-i];
            vecs[i].exp_gnt = gnt_pat[21-i];
            vecs[i].exp_ack = ack_pat[21-i];
        end

        reset = 1'b0;
        bd_we = 1'b0; bd_addr = 10'd0; bd_data = 8'd0;
        cpu_addr = 16'h0000; cpu_dout = 8'h00; cpu_we = 1'b0;
        // DMA and CPU both ask to write during reset: nothing may get through
        dma_req = 1'b1; dma_addr = 16'h0020; dma_wdata = 8'hFF; dma_we = 1'b1;
        cpu_we = 1'b1;
        #1;
        preload(10'h200, 8'h5A);
        preload(10'h010, 8'h11);
        preload(10'h020, 8'h22);
        preload(10'h040, 8'h33);

        // ---- reset state ----
        @(negedge clk);
        check("rst_gnt", {31'd0, dma_gnt}, 32'd0);
        check("rst_rdy", {31'd0, cpu_rdy}, 32'd1);
        check("rst_ack", {31'd0, dma_ack}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_dma_rdata", {24'd0, dma_rdata}, 32'd0);

        // ---- CPU-only read of 0x0200 ----
        dma_req = 1'b0; dma_we = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0200;
        #1 reset = 1'b1;
        #1;
        check("cpu_rd_rdy", {31'd0, cpu_rdy}, 32'd1);
        check("cpu_rd_gnt", {31'd0, dma_gnt}, 32'd0);
        check("cpu_rd_addr", {16'd0, mem_addr}, 32'h0200);
        next_cycle();
        cpu_addr = 16'h0010;
        @(negedge clk);
        check("cpu_rd_din", {24'd0, cpu_din}, 32'h5A);
        check("cpu_rd_ack", {31'd0, dma_ack}, 32'd0);
        check("cpu_rd_rdy2", {31'd0, cpu_rdy}, 32'd1);
        next_cycle();

        // ---- table: burst fairness, early drop, fresh burst, stall stability ----
        dma_addr = 16'h0020; dma_we = 1'b0;
        for (int i = 0; i < 22; i++) begin
            dma_req = vecs[i].req;
            @(negedge clk);
            g = vecs[i].exp_gnt;
            check($sformatf("v%0d_gnt", i), {31'd0, dma_gnt}, {31'd0, g});
            check($sformatf("v%0d_rdy", i), {31'd0, cpu_rdy}, {31'd0, ~g});
            check($sformatf("v%0d_ack", i), {31'd0, dma_ack}, {31'd0, vecs[i].exp_ack});
            check($sformatf("v%0d_addr", i), {16'd0, mem_addr}, g ? 32'h0020 : 32'h0010);
            check($sformatf("v%0d_cpu_din", i), {24'd0, cpu_din}, 32'h11);
            if (vecs[i].exp_ack)
                check($sformatf("v%0d_dma_rdata", i), {24'd0, dma_rdata}, 32'h22);
            next_cycle();
        end

        // ---- DMA write with a stalled CPU write ----
        dma_req = 1'b1; dma_addr = 16'h0300; dma_wdata = 8'hA5; dma_we = 1'b1;
        cpu_addr = 16'h0040; cpu_dout = 8'hEE; cpu_we = 1'b1;
        @(negedge clk);
        check("wr_gnt", {31'd0, dma_gnt}, 32'd1);
        check("wr_mem_we", {31'd0, mem_we}, 32'd1);
        check("wr_mem_addr", {16'd0, mem_addr}, 32'h0300);
        check("wr_mem_wdata", {24'd0, mem_wdata}, 32'hA5);
        next_cycle();
        dma_req = 1'b0; cpu_addr = 16'h0300; cpu_we = 1'b0;
        @(negedge clk);
        check("wr_ack", {31'd0, dma_ack}, 32'd1);
        check("wr_ungranted_we", {31'd0, mem_we}, 32'd0);
        check("wr_cpu_hold", {24'd0, cpu_din}, 32'h11);
        next_cycle();
        cpu_addr = 16'h0040;
        @(negedge clk);
        check("wr_cpu_readback", {24'd0, cpu_din}, 32'hA5);
        check("wr_ack_clear", {31'd0, dma_ack}, 32'd0);
        next_cycle();
        cpu_we = 1'b1; cpu_dout = 8'h77;
        @(negedge clk);
        check("stalled_wr_blocked", {24'd0, cpu_din}, 32'h33);
        check("cpu_wr_we", {31'd0, mem_we}, 32'd1);
        check("cpu_wr_wdata", {24'd0, mem_wdata}, 32'h77);
        next_cycle();
        cpu_we = 1'b0;
        next_cycle();
        @(negedge clk);
        check("cpu_wr_readback", {24'd0, cpu_din}, 32'h77);
        next_cycle();

        // ---- asynchronous reset in cycle 2 of a burst ----
        dma_req = 1'b1; dma_addr = 16'h0020; dma_wdata = 8'h99; dma_we = 1'b1;
        cpu_addr = 16'h0010;
        @(negedge clk);
        check("ar_c0_gnt", {31'd0, dma_gnt}, 32'd1);
        next_cycle();
        @(negedge clk);
        check("ar_c1_gnt", {31'd0, dma_gnt}, 32'd1);
        next_cycle();
        check("ar_c2_gnt_pre", {31'd0, dma_gnt}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("ar_gnt", {31'd0, dma_gnt}, 32'd0);
        check("ar_rdy", {31'd0, cpu_rdy}, 32'd1);
        check("ar_mem_we", {31'd0, mem_we}, 32'd0);
        check("ar_ack", {31'd0, dma_ack}, 32'd0);
        check("ar_mem_addr", {16'd0, mem_addr}, 32'h0010);
        @(posedge clk);
        @(negedge clk);
        check("ar_ack_hold", {31'd0, dma_ack}, 32'd0);
        dma_req = 1'b0; dma_we = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("ar_rel_gnt", {31'd0, dma_gnt}, 32'd0);
        check("ar_rel_rdy", {31'd0, cpu_rdy}, 32'd1);
        check("ar_rel_ack", {31'd0, dma_ack}, 32'd0);
        next_cycle();
        // counter restarted at 0: a full burst of 4 then the CPU slot
        dma_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("ar_burst%0d_gnt", i), {31'd0, dma_gnt}, (i < 4) ? 32'd1 : 32'd0);
            next_cycle();
        end
        dma_req = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
